// File: rtl/muxn_pipe_reg_if.sv
// Handshake bundle for muxn_pipe_reg: selector inputs, flush and the
// flow-controlled output stage.
interface muxn_pipe_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush;

    modport master (
        output in_data, sel, in_valid, out_ready, flush,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, sel, in_valid, out_ready, flush,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/muxn_pipe_reg.sv
// N:1 selector feeding a 2-entry skid buffer with registered in_ready.
// Define MUXN_SEL_ERR_EN to add the sticky sel_err flag and err_cnt counter.
module muxn_pipe_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic               clk,
    input  logic               rst,
    muxn_pipe_reg_if.slave     bus
`ifdef MUXN_SEL_ERR_EN
    ,
    output logic               sel_err,
    output logic [7:0]         err_cnt
`endif
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] word;
    logic             sel_oor;
    logic             accept;
    logic             pop;

    // Out-of-range select falls through every compare and leaves word at 0.
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(bus.sel) == k) word = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign sel_oor = int'(bus.sel) >= NUM_IN;
    assign accept  = bus.in_valid & rdy_q;
    assign pop     = (state_q != S_EMPTY) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        main_d  = word;
                    end
                end
                S_ONE: begin
                    if (accept && !pop) begin
                        state_d = S_TWO;
                        skid_d  = word;
                    end else if (accept && pop) begin
                        main_d  = word;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        rdy_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.out_data  = main_q;

`ifdef MUXN_SEL_ERR_EN
    logic       sel_err_q, sel_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_hit;

    // A word dropped by flush never entered the pipe, so it is not an error.
    assign err_hit = accept & ~bus.flush & sel_oor;

    always_comb begin
        sel_err_d = sel_err_q | err_hit;
        err_cnt_d = err_cnt_q;
        if (err_hit && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sel_err = sel_err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_oor;
    assign unused_oor = sel_oor;
`endif
endmodule

// File: tb/tb_muxn_pipe_reg.sv
// Directed bench for muxn_pipe_reg: a 4-input 32-bit instance and a
// 3-input 8-bit instance for out-of-range selection.
module tb_muxn_pipe_reg;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    muxn_pipe_reg_if #(.WIDTH(32), .NUM_IN(4)) a_if ();
    muxn_pipe_reg_if #(.WIDTH(8),  .NUM_IN(3)) b_if ();

`ifdef MUXN_SEL_ERR_EN
    logic       a_sel_err;
    logic [7:0] a_err_cnt;
    logic       b_sel_err;
    logic [7:0] b_err_cnt;
`endif

    muxn_pipe_reg #(.WIDTH(32), .NUM_IN(4)) u_a (
        .clk     (clk),
        .rst     (rst),
        .bus     (a_if.slave)
`ifdef MUXN_SEL_ERR_EN
        ,
        .sel_err (a_sel_err),
        .err_cnt (a_err_cnt)
`endif
    );

    muxn_pipe_reg #(.WIDTH(8), .NUM_IN(3)) u_b (
        .clk     (clk),
        .rst     (rst),
        .bus     (b_if.slave)
`ifdef MUXN_SEL_ERR_EN
        ,
        .sel_err (b_sel_err),
        .err_cnt (b_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        a_if.in_data   = '0;
        a_if.sel       = '0;
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b0;
        a_if.flush     = 1'b0;
        b_if.in_data   = '0;
        b_if.sel       = '0;
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b0;
        b_if.flush     = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // reset release
        tick();
        chk("rst_vld", 32'(a_if.out_valid), 32'd0);
        chk("rst_dat", a_if.out_data, 32'd0);
        chk("rst_rdy", 32'(a_if.in_ready), 32'd1);

        // streaming sel=2
        a_if.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        a_if.sel       = 2'd2;
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("str_vld", 32'(a_if.out_valid), 32'd1);
            chk("str_dat", a_if.out_data, 32'hA2);
            chk("str_rdy", 32'(a_if.in_ready), 32'd1);
        end
        a_if.in_valid = 1'b0;
        tick();
        chk("drain_vld", 32'(a_if.out_valid), 32'd0);
        chk("empty_keep", a_if.out_data, 32'hA2);

        // backpressure
        a_if.out_ready = 1'b0;
        a_if.sel       = 2'd0;
        a_if.in_data   = {32'h0, 32'h0, 32'h0, 32'h11};
        a_if.in_valid  = 1'b1;
        tick();
        chk("bp1_dat", a_if.out_data, 32'h11);
        chk("bp1_rdy", 32'(a_if.in_ready), 32'd1);
        a_if.in_data = {32'h0, 32'h0, 32'h0, 32'h22};
        tick();
        chk("bp2_rdy", 32'(a_if.in_ready), 32'd0);
        chk("bp2_dat", a_if.out_data, 32'h11);
        a_if.in_data = {32'h0, 32'h0, 32'h0, 32'h99};
        tick();
        chk("stall_dat", a_if.out_data, 32'h11);
        chk("stall_vld", 32'(a_if.out_valid), 32'd1);
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        tick();
        chk("pop1_dat", a_if.out_data, 32'h22);
        chk("pop1_rdy", 32'(a_if.in_ready), 32'd1);
        tick();
        chk("pop2_vld", 32'(a_if.out_valid), 32'd0);

        // flush while TWO with in_valid
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = {32'h0, 32'h0, 32'h0, 32'h33};
        tick();
        a_if.in_data = {32'h0, 32'h0, 32'h0, 32'h44};
        tick();
        chk("fl_pre_rdy", 32'(a_if.in_ready), 32'd0);
        a_if.in_data = {32'h0, 32'h0, 32'h0, 32'h55};
        a_if.flush   = 1'b1;
        tick();
        chk("fl_vld", 32'(a_if.out_valid), 32'd0);
        chk("fl_rdy", 32'(a_if.in_ready), 32'd1);
        a_if.in_data = {32'h0, 32'h0, 32'h0, 32'h66};
        tick();
        chk("fl_acc_vld", 32'(a_if.out_valid), 32'd0);
        a_if.flush    = 1'b0;
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b1;
        tick();
        chk("fl_after", 32'(a_if.out_valid), 32'd0);

        // out-of-range select on 3-input instance
        b_if.in_data   = {8'h33, 8'h22, 8'h11};
        b_if.sel       = 2'd1;
        b_if.in_valid  = 1'b1;
        b_if.out_ready = 1'b1;
        tick();
        chk("b_in_dat", 32'(b_if.out_data), 32'h22);
`ifdef MUXN_SEL_ERR_EN
        chk("b_noerr", 32'(b_sel_err), 32'd0);
`endif
        b_if.sel = 2'd3;
        tick();
        chk("b_oor_dat", 32'(b_if.out_data), 32'h0);
        chk("b_oor_vld", 32'(b_if.out_valid), 32'd1);
`ifdef MUXN_SEL_ERR_EN
        chk("b_err", 32'(b_sel_err), 32'd1);
        chk("b_cnt1", 32'(b_err_cnt), 32'd1);
`endif
        b_if.flush = 1'b1;
        tick();
        chk("b_fl_vld", 32'(b_if.out_valid), 32'd0);
`ifdef MUXN_SEL_ERR_EN
        chk("b_fl_cnt", 32'(b_err_cnt), 32'd1);
        chk("b_fl_err", 32'(b_sel_err), 32'd1);
`endif
        b_if.flush = 1'b0;
        repeat (299) tick();
`ifdef MUXN_SEL_ERR_EN
        chk("b_sat", 32'(b_err_cnt), 32'd255);
`endif
        chk("b_sat_dat", 32'(b_if.out_data), 32'h0);
        b_if.in_valid = 1'b0;

        // async reset while TWO
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = {32'h0, 32'h0, 32'h0, 32'h77};
        tick();
        a_if.in_data = {32'h0, 32'h0, 32'h0, 32'h88};
        tick();
        chk("ar_pre_rdy", 32'(a_if.in_ready), 32'd0);
        a_if.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("ar_vld", 32'(a_if.out_valid), 32'd0);
        chk("ar_dat", a_if.out_data, 32'd0);
        chk("ar_rdy", 32'(a_if.in_ready), 32'd1);
`ifdef MUXN_SEL_ERR_EN
        chk("ar_berr", 32'(b_sel_err), 32'd0);
        chk("ar_bcnt", 32'(b_err_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        a_if.out_ready = 1'b1;
        tick();
        chk("ar_post1", 32'(a_if.out_valid), 32'd0);
        tick();
        chk("ar_post2", 32'(a_if.out_valid), 32'd0);
        chk("ar_post_dat", a_if.out_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
